// File: rtl/pc_unit_stack.sv
// Program counter with increment, jump, relative branch, call/return via an internal
// return-address stack, and stall. All state updates on the falling clock edge.
module pc_unit_stack #(
  parameter int              PC_W        = 16,
  parameter int              OFF_W       = 8,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  localparam int             SP_W        = $clog2(STACK_DEPTH + 1),
  localparam int             AW          = $clog2(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jmp_en,
  input  logic [PC_W-1:0]  jmp_addr,
  input  logic             br_en,
  input  logic [OFF_W-1:0] br_off,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [PC_W-1:0]  pc,
  output logic [SP_W-1:0]  sp,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_ovf,
  output logic             stk_unf
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic [PC_W-1:0] stk_q [STACK_DEPTH];

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_tgt;
  logic [SP_W-1:0] sp_m1;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic            push;
  logic            full, empty;

  assign pc_inc = pc_q + PC_W'(1);
  assign br_tgt = pc_q + PC_W'($signed(br_off));
  assign sp_m1  = sp_q - SP_W'(1);
  // Both indices are in range whenever they are used: push only when not full, pop only when not empty.
  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = sp_m1[AW-1:0];
  assign full   = (sp_q == SP_W'(STACK_DEPTH));
  assign empty  = (sp_q == '0);

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (ret_en) begin
      if (empty) begin
        pc_d  = pc_inc;
        unf_d = 1'b1;
      end else begin
        pc_d = stk_q[rd_idx];
        sp_d = sp_m1;
      end
    end else if (call_en) begin
      pc_d = jmp_addr;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push = 1'b1;
        sp_d = sp_q + SP_W'(1);
      end
    end else if (jmp_en) begin
      pc_d = jmp_addr;
    end else if (br_en) begin
      pc_d = br_tgt;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage carries no reset; reset only has to suppress a push in flight.
  always_ff @(negedge clk) begin
    if (push && !rst) stk_q[wr_idx] <= pc_inc;
  end

  assign pc        = pc_q;
  assign sp        = sp_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule
